// File: rtl/parser_pkg.sv
// Shared types and constants for the parser front end.
package parser_pkg;

  localparam int HEAD_WIDTH_DEF = 1024;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int ERR_CNT_W      = 16;
  localparam int TS_W           = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_EMIT = 2'd2,
    S_SKIP = 2'd3
  } head_asm_state_t;

endpackage

// File: rtl/head_beat_buf.sv
// Header window register: beat-indexed write, clear-on-start and beat counter.
module head_beat_buf
  import parser_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int HEAD_WIDTH = HEAD_WIDTH_DEF,
  localparam int BEAT_NUM  = HEAD_WIDTH / DATA_WIDTH,
  localparam int CNT_W     = $clog2(BEAT_NUM + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_append,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [HEAD_WIDTH-1:0] o_head,
  output logic [CNT_W-1:0]      o_beats,
  output logic                  o_last
);

  logic [HEAD_WIDTH-1:0] head_q;
  logic [CNT_W-1:0]      cnt_q;

  // Starting a header drops all previous content so short packets read back zero-padded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      cnt_q  <= '0;
    end else if (i_start) begin
      head_q <= {i_data, {(HEAD_WIDTH-DATA_WIDTH){1'b0}}};
      cnt_q  <= CNT_W'(1);
    end else if (i_append) begin
      for (int k = 0; k < BEAT_NUM; k++) begin
        if (cnt_q == CNT_W'(k))
          head_q[HEAD_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] <= i_data;
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_head  = head_q;
  assign o_beats = cnt_q;
  // Next appended beat is the final slot of the window.
  assign o_last  = (cnt_q == CNT_W'(BEAT_NUM - 1));

endmodule

// File: rtl/head_assembler.sv
// Collects the first HEAD_WIDTH bits of each packet and hands them on via valid/ready.
// Optional sop timestamping is built when HEAD_TIMESTAMP_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a sop beat
// FILL   | collecting header beats
// EMIT   | header presented, ingress stalled until handshake
// SKIP   | sinking payload beats until eop
module head_assembler
  import parser_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int HEAD_WIDTH = HEAD_WIDTH_DEF,
  localparam int BEAT_NUM  = HEAD_WIDTH / DATA_WIDTH,
  localparam int CNT_W     = $clog2(BEAT_NUM + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_sop,
  input  logic                  i_data_eop,
  output logic                  o_data_ready,
  output logic                  o_head_valid,
  input  logic                  i_head_ready,
  output logic [HEAD_WIDTH-1:0] o_head,
  output logic [CNT_W-1:0]      o_head_beats,
  output logic [TS_W-1:0]       o_head_ts,
  output logic [ERR_CNT_W-1:0]  o_err_cnt
);

  head_asm_state_t        state_q, state_d;
  logic                   eop_seen_q, eop_seen_d;
  logic                   buf_start, buf_append, buf_last;
  logic                   err_inc;
  logic                   xfer;
  logic [ERR_CNT_W-1:0]   err_q;

  // Ready and valid decode straight from the state flop, never from the inputs.
  assign o_data_ready = (state_q != S_EMIT);
  assign o_head_valid = (state_q == S_EMIT);
  assign xfer         = i_data_valid && o_data_ready;

  head_beat_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .HEAD_WIDTH (HEAD_WIDTH)
  ) u_buf (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (buf_start),
    .i_append (buf_append),
    .i_data   (i_data),
    .o_head   (o_head),
    .o_beats  (o_head_beats),
    .o_last   (buf_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      eop_seen_q <= eop_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    eop_seen_d = eop_seen_q;
    buf_start  = 1'b0;
    buf_append = 1'b0;
    err_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (i_data_sop) begin
            buf_start  = 1'b1;
            eop_seen_d = i_data_eop;
            state_d    = i_data_eop ? S_EMIT : S_FILL;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (xfer) begin
          if (i_data_sop) begin
            // Restart: the interrupted header is abandoned.
            err_inc    = 1'b1;
            buf_start  = 1'b1;
            eop_seen_d = i_data_eop;
            state_d    = i_data_eop ? S_EMIT : S_FILL;
          end else begin
            buf_append = 1'b1;
            if (i_data_eop || buf_last) begin
              eop_seen_d = i_data_eop;
              state_d    = S_EMIT;
            end
          end
        end
      end
      S_EMIT: begin
        if (i_head_ready)
          state_d = eop_seen_q ? S_IDLE : S_SKIP;
      end
      S_SKIP: begin
        if (xfer) begin
          if (i_data_sop) begin
            err_inc    = 1'b1;
            buf_start  = 1'b1;
            eop_seen_d = i_data_eop;
            state_d    = i_data_eop ? S_EMIT : S_FILL;
          end else if (i_data_eop) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      err_q <= '0;
    else if (err_inc && (err_q != '1))
      err_q <= err_q + ERR_CNT_W'(1);
  end

  assign o_err_cnt = err_q;

`ifdef HEAD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      if (buf_start)
        ts_q <= ts_cnt_q;
    end
  end

  assign o_head_ts = ts_q;
`else
  assign o_head_ts = '0;
`endif

endmodule

// File: tb/tb_head_assembler.sv
// Directed bench for head_assembler with DATA_WIDTH=128, HEAD_WIDTH=512.
module tb_head_assembler;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_data_valid;
  logic [127:0] i_data;
  logic         i_data_sop;
  logic         i_data_eop;
  logic         o_data_ready;
  logic         o_head_valid;
  logic         i_head_ready;
  logic [511:0] o_head;
  logic [2:0]   o_head_beats;
  logic [31:0]  o_head_ts;
  logic [15:0]  o_err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  head_assembler #(.DATA_WIDTH(128), .HEAD_WIDTH(512)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .i_data_sop   (i_data_sop),
    .i_data_eop   (i_data_eop),
    .o_data_ready (o_data_ready),
    .o_head_valid (o_head_valid),
    .i_head_ready (i_head_ready),
    .o_head       (o_head),
    .o_head_beats (o_head_beats),
    .o_head_ts    (o_head_ts),
    .o_err_cnt    (o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

`ifdef HEAD_TIMESTAMP_EN
  logic [31:0] tb_cyc;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tb_cyc <= 32'd0;
    else          tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic push(input logic [127:0] d, input logic s, input logic e);
    int n;
    n = 0;
    i_data_valid = 1'b1;
    i_data       = d;
    i_data_sop   = s;
    i_data_eop   = e;
    while (!o_data_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20) chk("push_timeout", 512'(o_data_ready), 512'(1'b1));
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_data_valid = 1'b0;
    i_data_sop   = 1'b0;
    i_data_eop   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp_head;
    i_rst_n      = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_data_sop   = 1'b0;
    i_data_eop   = 1'b0;
    i_head_ready = 1'b1;
    #3;
    chk("rst_valid", 512'(o_head_valid), 512'(1'b0));
    chk("rst_head",  o_head, 512'(0));
    chk("rst_beats", 512'(o_head_beats), 512'(0));
    chk("rst_err",   512'(o_err_cnt), 512'(0));
    chk("rst_ts",    512'(o_head_ts), 512'(0));
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("rst_ready", 512'(o_data_ready), 512'(1'b1));

    // 6-beat packet, header window takes the first 4 beats
    push(pat(8'h11), 1'b1, 1'b0);
    push(pat(8'h22), 1'b0, 1'b0);
    push(pat(8'h33), 1'b0, 1'b0);
    chk("t1_valid_early", 512'(o_head_valid), 512'(1'b0));
    push(pat(8'h44), 1'b0, 1'b0);
    chk("t1_valid", 512'(o_head_valid), 512'(1'b1));
    chk("t1_head", o_head, {pat(8'h11), pat(8'h22), pat(8'h33), pat(8'h44)});
    chk("t1_beats", 512'(o_head_beats), 512'(3'd4));
`ifndef HEAD_TIMESTAMP_EN
    chk("t1_ts", 512'(o_head_ts), 512'(0));
`endif
    push(pat(8'h55), 1'b0, 1'b0);
    push(pat(8'h66), 1'b0, 1'b1);
    idle();
    chk("t1_err", 512'(o_err_cnt), 512'(0));
    chk("t1_valid_after", 512'(o_head_valid), 512'(1'b0));

    // backpressure in EMIT for 10 cycles
    i_head_ready = 1'b0;
    push(pat(8'h81), 1'b1, 1'b0);
    push(pat(8'h82), 1'b0, 1'b0);
    push(pat(8'h83), 1'b0, 1'b0);
    push(pat(8'h84), 1'b0, 1'b0);
    idle();
    exp_head = {pat(8'h81), pat(8'h82), pat(8'h83), pat(8'h84)};
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid_hold", 512'(o_head_valid), 512'(1'b1));
      chk("t3_head_hold", o_head, exp_head);
      chk("t3_ready_low", 512'(o_data_ready), 512'(1'b0));
      @(negedge i_clk);
    end
    i_head_ready = 1'b1;
    @(negedge i_clk);
    chk("t3_handshake", 512'(o_head_valid), 512'(1'b0));
    push(pat(8'h85), 1'b0, 1'b1);
    idle();
    chk("t3_err", 512'(o_err_cnt), 512'(0));

    // 2-beat short packet, zero padded
    push(pat(8'hAA), 1'b1, 1'b0);
    push(pat(8'hBB), 1'b0, 1'b1);
    idle();
    chk("t2_valid", 512'(o_head_valid), 512'(1'b1));
    chk("t2_head", o_head, {pat(8'hAA), pat(8'hBB), 256'h0});
    chk("t2_beats", 512'(o_head_beats), 512'(3'd2));
    @(negedge i_clk);

    // stray beat (must land in IDLE), then sop restarting in FILL
    push(pat(8'hC0), 1'b0, 1'b0);
    chk("t4_err_idle", 512'(o_err_cnt), 512'(16'd1));
    push(pat(8'hC1), 1'b1, 1'b0);
    push(pat(8'hC2), 1'b0, 1'b0);
    push(pat(8'hD1), 1'b1, 1'b0);
    push(pat(8'hD2), 1'b0, 1'b0);
    push(pat(8'hD3), 1'b0, 1'b1);
    idle();
    chk("t4_err", 512'(o_err_cnt), 512'(16'd2));
    chk("t4_head", o_head, {pat(8'hD1), pat(8'hD2), pat(8'hD3), 128'h0});
    chk("t4_beats", 512'(o_head_beats), 512'(3'd3));
    @(negedge i_clk);

    // reset mid-FILL
    push(pat(8'hE1), 1'b1, 1'b0);
    push(pat(8'hE2), 1'b0, 1'b0);
    i_data_valid = 1'b1;
    i_data       = pat(8'hE3);
    i_rst_n      = 1'b0;
    #1;
    chk("t5_valid", 512'(o_head_valid), 512'(1'b0));
    chk("t5_head", o_head, 512'(0));
    chk("t5_beats", 512'(o_head_beats), 512'(0));
    chk("t5_err", 512'(o_err_cnt), 512'(0));
    chk("t5_ts", 512'(o_head_ts), 512'(0));
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("t5_ready", 512'(o_data_ready), 512'(1'b1));
    push(pat(8'hE4), 1'b0, 1'b1);
    chk("t5_err_tail", 512'(o_err_cnt), 512'(16'd1));
    push(pat(8'hF1), 1'b1, 1'b0);
    push(pat(8'hF2), 1'b0, 1'b0);
    push(pat(8'hF3), 1'b0, 1'b0);
    push(pat(8'hF4), 1'b0, 1'b1);
    idle();
    chk("t5_head", o_head, {pat(8'hF1), pat(8'hF2), pat(8'hF3), pat(8'hF4)});
    chk("t5_fbeats", 512'(o_head_beats), 512'(3'd4));
    @(negedge i_clk);
    // eop on the last window beat returns to IDLE, so a stray beat is an error
    push(pat(8'hF5), 1'b0, 1'b0);
    idle();
    chk("t5_err_idle", 512'(o_err_cnt), 512'(16'd2));

    // single-beat packets and timestamps
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
`ifdef HEAD_TIMESTAMP_EN
    while (tb_cyc < 32'd100) @(negedge i_clk);
    push(pat(8'h31), 1'b1, 1'b1);
    idle();
    chk("t6_ts0", 512'(o_head_ts), 512'(32'd100));
    chk("t6_beats", 512'(o_head_beats), 512'(3'd1));
    chk("t6_head", o_head, {pat(8'h31), 384'h0});
    while (tb_cyc < 32'd107) @(negedge i_clk);
    push(pat(8'h32), 1'b1, 1'b1);
    idle();
    chk("t6_ts1", 512'(o_head_ts), 512'(32'd107));
`else
    repeat (5) @(negedge i_clk);
    push(pat(8'h31), 1'b1, 1'b1);
    idle();
    chk("t6_ts0", 512'(o_head_ts), 512'(0));
    chk("t6_beats", 512'(o_head_beats), 512'(3'd1));
    chk("t6_head", o_head, {pat(8'h31), 384'h0});
    repeat (3) @(negedge i_clk);
    push(pat(8'h32), 1'b1, 1'b1);
    idle();
    chk("t6_ts1", 512'(o_head_ts), 512'(0));
`endif
    chk("t6_valid", 512'(o_head_valid), 512'(1'b1));
    @(negedge i_clk);
    chk("t6_err", 512'(o_err_cnt), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
